// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared CPU constants for the 16 x 32 register bank and the logic that writes back into it.
package regbank_wb_arbiter_pkg;

  localparam int unsigned CPU_ADDR_W   = 4;
  localparam int unsigned CPU_DATA_W   = 32;
  localparam int unsigned CPU_NUM_REGS = 2 ** CPU_ADDR_W;
  localparam int unsigned CPU_ZERO_REG = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts at ptr, first valid requester wins; one-hot grant.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < int'(N); k++) begin
      idx = int'(ptr) + k;
      if (idx >= int'(N)) idx = idx - int'(N);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter for the register bank: round-robin request selection, one-cycle registered
// write port, and a pending-write scoreboard used for read-port hazard detection.
module regbank_wb_arbiter
  import regbank_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = CPU_ADDR_W,
  parameter int unsigned DATA_W = CPU_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_regnum,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_regnum,
  input  logic [ADDR_W-1:0]      chk_regnum0,
  input  logic [ADDR_W-1:0]      chk_regnum1,
  output logic                   chk_hazard0,
  output logic                   chk_hazard1,
  input  logic                   flush,
  output logic [DATA_W-1:0]      wDataIn,
  output logic [ADDR_W-1:0]      wRegNum,
  output logic                   writeEnable,
  output logic [2**ADDR_W-1:0]   pending,
  output logic                   rsv_conflict
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(CPU_ZERO_REG);

  logic [PTR_W-1:0]  rr_ptr, rr_ptr_d;
  logic [NREQ-1:0]   grant;
  logic              accept;
  logic [PTR_W-1:0]  gnt_idx;
  logic [ADDR_W-1:0] sel_regnum;
  logic [DATA_W-1:0] sel_data;
  logic [NREGS-1:0]  set_vec, clr_vec, pending_d;
  logic              rsv_set, conflict_now;

  rr_arbiter #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign req_ready = reset ? '0 : grant;
  assign accept    = |req_ready;

  always_comb begin
    gnt_idx    = '0;
    sel_regnum = '0;
    sel_data   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        gnt_idx    = PTR_W'(i);
        sel_regnum = req_regnum[i*ADDR_W +: ADDR_W];
        sel_data   = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr;
    if (accept) rr_ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Scoreboard: a set on the same edge as a commit-clear (or a flush) wins.
  always_comb begin
    rsv_set = rsv_valid && (rsv_regnum != ZERO_REG);
    set_vec = '0;
    clr_vec = '0;
    if (rsv_set) set_vec[rsv_regnum] = 1'b1;
    if (writeEnable) clr_vec[wRegNum] = 1'b1;
    pending_d    = (flush ? '0 : (pending & ~clr_vec)) | set_vec;
    conflict_now = rsv_set && pending[rsv_regnum] && !clr_vec[rsv_regnum];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr       <= '0;
      writeEnable  <= 1'b0;
      wRegNum      <= '0;
      wDataIn      <= '0;
      pending      <= '0;
      rsv_conflict <= 1'b0;
    end else begin
      rr_ptr       <= rr_ptr_d;
      writeEnable  <= accept && (sel_regnum != ZERO_REG);
      if (accept) begin
        wRegNum <= sel_regnum;
        wDataIn <= sel_data;
      end
      pending      <= pending_d;
      rsv_conflict <= rsv_conflict | conflict_now;
    end
  end

  assign chk_hazard0 = (chk_regnum0 != ZERO_REG) &&
                       (pending[chk_regnum0] || (writeEnable && (wRegNum == chk_regnum0)));
  assign chk_hazard1 = (chk_regnum1 != ZERO_REG) &&
                       (pending[chk_regnum1] || (writeEnable && (wRegNum == chk_regnum1)));

endmodule
